// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential 32x32 multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NEG_A,
    ST_NEG_B,
    ST_MUL,
    ST_NEG_LO,
    ST_NEG_HI,
    ST_DONE
  } mul_state_e;

  localparam int MUL_ITER    = 32;
  localparam int MUL_LATENCY = 36;

endpackage

// File: rtl/brent_kung_adder_32b.sv
// 32-bit Brent-Kung parallel-prefix adder with carry in and carry out.
module brent_kung_adder_32b (
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        carry_o
);

  logic [31:0] gen;
  logic [31:0] prop;
  logic [31:0] gg;
  logic [31:0] pp;
  logic [32:0] carry;

  always_comb begin
    gen  = op1_i & op2_i;
    prop = op1_i ^ op2_i;
    gg   = gen;
    pp   = prop;
    // Up-sweep builds power-of-two group terms; down-sweep fills in the gaps.
    for (int lv = 0; lv < 5; lv++) begin
      for (int i = 0; i < 32; i++) begin
        int s;
        int j;
        s = 1 << lv;
        j = (i >= s) ? (i - s) : i;
        if (((i + 1) % (2 * s)) == 0) begin
          gg[i[4:0]] = gg[i[4:0]] | (pp[i[4:0]] & gg[j[4:0]]);
          pp[i[4:0]] = pp[i[4:0]] & pp[j[4:0]];
        end
      end
    end
    for (int lv = 0; lv < 4; lv++) begin
      for (int i = 0; i < 32; i++) begin
        int s;
        int j;
        s = 8 >> lv;
        j = (i >= s) ? (i - s) : i;
        if ((((i + 1) % (2 * s)) == s) && (i >= 2 * s)) begin
          gg[i[4:0]] = gg[i[4:0]] | (pp[i[4:0]] & gg[j[4:0]]);
          pp[i[4:0]] = pp[i[4:0]] & pp[j[4:0]];
        end
      end
    end
    carry[0] = cin_i;
    for (int i = 0; i < 32; i++) begin
      carry[i + 1] = gg[i[4:0]] | (pp[i[4:0]] & cin_i);
    end
  end

  assign sum_o   = prop ^ carry[31:0];
  assign carry_o = carry[32];

endmodule

// File: rtl/seq_multiplier_32b.sv
// Multi-cycle radix-2 shift-add multiplier sharing one adder for sign
// correction and accumulation; returns the selected half of the product.
module seq_multiplier_32b
  import mul_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic [1:0]  op_i,
  input  logic        kill_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o,
  output logic        busy_o
);

  mul_state_e  state_q;
  mul_state_e  state_d;
  mul_op_e     op_q;
  logic [31:0] a_q;
  logic [63:0] p_q;
  logic [4:0]  cnt_q;
  logic        c_q;
  logic        neg_res_q;
  logic        sa_q;
  logic        sb_q;
  logic        sa;
  logic        sb;

  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_sum;
  logic        add_carry;

  assign sa = op1_i[31] & ((op_i == OP_MULH) | (op_i == OP_MULHSU));
  assign sb = op2_i[31] & (op_i == OP_MULH);

  brent_kung_adder_32b u_adder (
    .op1_i   (add_a),
    .op2_i   (add_b),
    .cin_i   (add_cin),
    .sum_o   (add_sum),
    .carry_o (add_carry)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (valid_i) state_d = ST_NEG_A;
      ST_NEG_A:  state_d = ST_NEG_B;
      ST_NEG_B:  state_d = ST_MUL;
      ST_MUL:    if (cnt_q == 5'(MUL_ITER - 1)) state_d = ST_NEG_LO;
      ST_NEG_LO: state_d = ST_NEG_HI;
      ST_NEG_HI: state_d = ST_DONE;
      ST_DONE:   if (ready_i) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (kill_i && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

  // Negation steps reuse the adder as ~x + cin; MUL accumulates the upper half.
  always_comb begin
    add_a   = 32'd0;
    add_b   = 32'd0;
    add_cin = 1'b0;
    case (state_q)
      ST_NEG_A:  begin add_a = ~a_q;         add_cin = 1'b1; end
      ST_NEG_B:  begin add_a = ~p_q[31:0];   add_cin = 1'b1; end
      ST_MUL:    begin add_a = p_q[63:32];   add_b = p_q[0] ? a_q : 32'd0; end
      ST_NEG_LO: begin add_a = ~p_q[31:0];   add_cin = 1'b1; end
      ST_NEG_HI: begin add_a = ~p_q[63:32];  add_cin = c_q; end
      default:   ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q       <= 32'd0;
      p_q       <= 64'd0;
      cnt_q     <= 5'd0;
      c_q       <= 1'b0;
      op_q      <= OP_MUL;
      neg_res_q <= 1'b0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (valid_i) begin
          a_q       <= op1_i;
          p_q       <= {32'd0, op2_i};
          op_q      <= mul_op_e'(op_i);
          sa_q      <= sa;
          sb_q      <= sb;
          neg_res_q <= sa ^ sb;
        end
        ST_NEG_A: if (sa_q) a_q <= add_sum;
        ST_NEG_B: begin
          if (sb_q) p_q[31:0] <= add_sum;
          cnt_q <= 5'd0;
        end
        ST_MUL: begin
          p_q   <= {add_carry, add_sum, p_q[31:1]};
          cnt_q <= cnt_q + 5'd1;
        end
        ST_NEG_LO: if (neg_res_q) begin
          p_q[31:0] <= add_sum;
          c_q       <= add_carry;
        end
        ST_NEG_HI: if (neg_res_q) p_q[63:32] <= add_sum;
        default: ;
      endcase
    end
  end

  assign ready_o  = (state_q == ST_IDLE);
  assign valid_o  = (state_q == ST_DONE);
  assign busy_o   = (state_q != ST_IDLE);
  assign result_o = (op_q == OP_MUL) ? p_q[31:0] : p_q[63:32];

endmodule

// File: tb/tb_seq_multiplier_32b.sv
// Directed, table-driven bench for the sequential multiplier.
module tb_seq_multiplier_32b;
  import mul_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] op1_i;
  logic [31:0] op2_i;
  logic [1:0]  op_i;
  logic        kill_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  seq_multiplier_32b dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .op1_i    (op1_i),
    .op2_i    (op2_i),
    .op_i     (op_i),
    .kill_i   (kill_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o),
    .busy_o   (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present one request for a single edge; the bench sits #1 past a rising edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    valid_i = 1'b1;
    op_i    = op;
    op1_i   = a;
    op2_i   = b;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic waitResult(output logic [31:0] res, output int lat);
    lat = 0;
    while (!valid_o && lat < 100) begin
      tick();
      lat++;
    end
    res = result_o;
  endtask

  task automatic runTxn(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    logic [31:0] res;
    int lat;
    applyStimulus(op, a, b);
    checkOutput({name, " busy"}, 32'(busy_o), 32'd1);
    waitResult(res, lat);
    checkOutput({name, " latency"}, 32'(lat), 32'(MUL_LATENCY));
    checkOutput({name, " result"}, res, exp);
    tick();
    checkOutput({name, " ready after"}, 32'(ready_o), 32'd1);
  endtask

  initial begin
    logic [31:0] held;
    int lat;

    vecs[0]  = '{2'b00, 32'h00000007, 32'h00000006, 32'h0000002A};
    vecs[1]  = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[2]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vecs[3]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[4]  = '{2'b01, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF};
    vecs[5]  = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1};
    vecs[6]  = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[7]  = '{2'b10, 32'h00000002, 32'h80000000, 32'h00000001};
    vecs[8]  = '{2'b11, 32'h80000000, 32'h00000004, 32'h00000002};
    vecs[9]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    vecs[10] = '{2'b01, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF};
    vecs[11] = '{2'b10, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF};
    vecs[12] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[13] = '{2'b11, 32'h00010000, 32'h00010000, 32'h00000001};
    vecs[14] = '{2'b01, 32'h00000000, 32'h80000000, 32'h00000000};

    rst_i   = 1'b1;
    valid_i = 1'b0;
    kill_i  = 1'b0;
    ready_i = 1'b1;
    op_i    = 2'b00;
    op1_i   = 32'd0;
    op2_i   = 32'd0;
    tick();
    tick();
    rst_i = 1'b0;
    checkOutput("reset ready_o", 32'(ready_o), 32'd1);
    checkOutput("reset valid_o", 32'(valid_o), 32'd0);
    checkOutput("reset busy_o", 32'(busy_o), 32'd0);
    checkOutput("reset result_o", result_o, 32'd0);

    for (int i = 0; i < NVEC; i++) begin
      runTxn($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
    end

    // Result held under backpressure; a stray request must be ignored.
    ready_i = 1'b0;
    applyStimulus(2'b00, 32'd7, 32'd6);
    waitResult(held, lat);
    checkOutput("bp latency", 32'(lat), 32'(MUL_LATENCY));
    for (int c = 0; c < 10; c++) begin
      if (c == 4) valid_i = 1'b1;
      op1_i = 32'd9;
      op2_i = 32'd9;
      tick();
      valid_i = 1'b0;
      checkOutput($sformatf("bp result c%0d", c), result_o, 32'h0000002A);
      checkOutput($sformatf("bp valid c%0d", c), 32'(valid_o), 32'd1);
      checkOutput($sformatf("bp ready c%0d", c), 32'(ready_o), 32'd0);
    end
    ready_i = 1'b1;
    tick();
    checkOutput("bp exit ready_o", 32'(ready_o), 32'd1);
    checkOutput("bp exit valid_o", 32'(valid_o), 32'd0);
    tick();
    checkOutput("bp no restart", 32'(busy_o), 32'd0);

    // Reset on the 10th MUL iteration (accept edge + 12).
    applyStimulus(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (11) tick();
    checkOutput("pre-rst busy", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checkOutput("rst ready_o", 32'(ready_o), 32'd1);
    checkOutput("rst valid_o", 32'(valid_o), 32'd0);
    checkOutput("rst result_o", result_o, 32'd0);
    runTxn("post-rst", 2'b00, 32'd3, 32'd4, 32'h0000000C);

    // Kill on the 10th MUL iteration.
    applyStimulus(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (11) tick();
    kill_i = 1'b1;
    tick();
    kill_i = 1'b0;
    checkOutput("kill ready_o", 32'(ready_o), 32'd1);
    checkOutput("kill valid_o", 32'(valid_o), 32'd0);
    runTxn("post-kill", 2'b00, 32'd3, 32'd4, 32'h0000000C);

    // Kill together with a request in IDLE still accepts it.
    kill_i = 1'b1;
    applyStimulus(2'b00, 32'd5, 32'd5);
    kill_i = 1'b0;
    checkOutput("idle kill busy", 32'(busy_o), 32'd1);
    waitResult(held, lat);
    checkOutput("idle kill latency", 32'(lat), 32'(MUL_LATENCY));
    checkOutput("idle kill result", held, 32'd25);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_multiplier_32b.md
# seq_multiplier_32b

Multi-cycle 32x32 integer multiplier built around a single shared `brent_kung_adder_32b` instance. It computes one product per transaction using radix-2 shift-add, with pre- and post-negation for the signed variants. It sits in the execute stage beside the ALU. It takes operands over a valid/ready handshake and returns the selected 32-bit half of the 64-bit product over a second valid/ready handshake.

## Interface
- No parameters. Width is fixed at 32 by the adder.
- Ports:
  - `clk_i` in 1: clock; all state updates on rising edge.
  - `rst_i` in 1: reset, synchronous, active-high. One clock; reset is synchronous and active-high.
  - `valid_i` in 1: request valid.
  - `ready_o` out 1: block can accept a request.
  - `op1_i` in 32: multiplicand (rs1).
  - `op2_i` in 32: multiplier (rs2).
  - `op_i` in 2: operation select.
    - 00 MUL: low 32 bits.
    - 01 MULH: signed x signed, high 32 bits.
    - 10 MULHSU: signed op1 x unsigned op2, high 32 bits.
    - 11 MULHU: unsigned x unsigned, high 32 bits.
  - `kill_i` in 1: synchronous abort of the in-flight operation.
  - `valid_o` out 1: result valid.
  - `ready_i` in 1: consumer accepts result.
  - `result_o` out 32: selected product half.
  - `busy_o` out 1: high in every state except IDLE.

## Operation
- State machine: IDLE, NEG_A, NEG_B, MUL, NEG_LO, NEG_HI, DONE.
- Registers:
  - `a_q[31:0]`: multiplicand magnitude.
  - `p_q[63:0]`: product and multiplier shift register.
  - `cnt_q[4:0]`: iteration counter.
  - `c_q`: carry between the two post-negation halves.
  - `op_q`: latched operation.
  - `neg_res_q`: result needs negating.
- MUL treats both operands as unsigned; its low half is sign-agnostic.
- IDLE: `ready_o`=1. When `valid_i` && `ready_o`, latch `a_q`=op1, `p_q`={32'b0, op2}, `op_q`, and sign flags, then go to NEG_A.
  - `sa` = op1[31] when op is MULH or MULHSU.
  - `sb` = op2[31] when op is MULH.
  - `neg_res_q` = `sa` ^ `sb`.
- NEG_A: adder computes ~`a_q` + 0 + cin 1. Write the sum into `a_q` only if `sa`. Go to NEG_B.
- NEG_B: same operation on `p_q[31:0]`, gated by `sb`. Clear `cnt_q`. Go to MUL.
- MUL, one iteration per cycle:
  - Adder inputs: op1 = `p_q[63:32]`, op2 = `p_q[0]` ? `a_q` : 0, cin 0.
  - Update: `p_q` <= {carry_o, sum, `p_q[31:1]`}. Increment `cnt_q`.
  - After the 32nd iteration (`cnt_q`==31) go to NEG_LO.
- NEG_LO: adder computes ~`p_q[31:0]` + 0 + cin 1. If `neg_res_q`, write the sum to `p_q[31:0]` and carry_o to `c_q`. Go to NEG_HI.
- NEG_HI: adder computes ~`p_q[63:32]` + 0 + cin `c_q`. If `neg_res_q`, write the sum to `p_q[63:32]`. Go to DONE.
- DONE: `valid_o`=1.
  - `result_o` = `op_q`==MUL ? `p_q[31:0]` : `p_q[63:32]`.
  - On `ready_i`, go to IDLE.
- Only one adder instance exists. All adder inputs are muxed by state.
- A magnitude of 0x80000000 (from -2^31) is representable unsigned. No special case is needed.
- `kill_i` in any state: next state is IDLE and `valid_o` drops. `rst_i` has priority over `kill_i`. `kill_i` in IDLE has no effect. If `kill_i` and `valid_i` are both high in IDLE, the request is accepted.

## Timing
- Reset values:
  - State: IDLE.
  - `ready_o`=1, `valid_o`=0, `busy_o`=0, `result_o`=0.
  - `p_q`, `a_q`, `cnt_q`, `c_q`, `neg_res_q` all 0.
- Fixed latency regardless of operands or signs:
  - Accept edge k enters NEG_A.
  - MUL iterations occupy edges k+3..k+34.
  - DONE is entered at edge k+36, so `valid_o` is high 36 cycles after the accept edge.
- `ready_o` is low from the cycle after accept until the cycle after DONE completes. There is no back-to-back accept in the DONE-exit cycle.
- Result handshake:
  - `result_o` and `valid_o` stay stable while `ready_i` is low.
  - `valid_i` is ignored while busy.
- `rst_i` mid-operation: the next cycle is IDLE with all reset values. The in-flight result is discarded.
- `result_o` is registered: driven from `p_q` and `op_q` only, not from the adder output.

## Structure
- `mul_pkg`:
  - `mul_op_e` enum with the 2-bit op encodings.
  - `mul_state_e` enum.
  - `MUL_ITER` = 32 and `MUL_LATENCY` = 36 constants.
- Sub-module: reuse `brent_kung_adder_32b` unchanged. No new sub-module.

## Test plan
- MUL 7 x 6 -> `result_o`=0x0000002A, `valid_o` high exactly 36 cycles after the accept edge.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MUL with the same operands -> 0x00000001.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULH 0xFFFFFFFD x 0x00000005 -> 0xFFFFFFFF. MUL with the same operands -> 0xFFFFFFF1.
- MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF (product 0xFFFFFFFF_00000001). MULHSU 0x00000002 x 0x80000000 -> 0x00000001.
- Backpressure: hold `ready_i` low 10 cycles in DONE -> `result_o` stable, `ready_o`=0, and a `valid_i` pulse is ignored. Raising `ready_i` -> IDLE the next cycle, `ready_o`=1.
- Assert `rst_i` (or `kill_i`) on the 10th MUL iteration -> next cycle `ready_o`=1 and `valid_o`=0. With `rst_i`, `result_o`=0. A following MUL 3 x 4 returns 0x0000000C with nominal latency.
